key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
Classifies one debounced key into discrete user events: short press, double click, long press and auto-repeat while held. It sits directly downstream of the per-key debouncer and consumes its debounced level and one-cycle valid flag. It emits one-cycle event pulses to application logic such as menu, mode or threshold controllers. All timing is counted in milliseconds from an internal 1 ms tick.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz; must be a multiple of 1000.
LONG_MS, 1000, hold time in ms before long_pulse; must be >= 2.
DCLICK_MS, 300, maximum gap in ms between first release and second press; must be >= 2.
REPEAT_MS, 200, repeat_pulse period in ms after long_pulse; must be >= 2.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
key_flag  in  1  one-cycle pulse from the debouncer; key_value is valid in this cycle
key_value  in  1  debounced level; 0 = pressed, 1 = released
short_pulse  out  1  one-cycle pulse: single short click
double_pulse  out  1  one-cycle pulse: double click
long_pulse  out  1  one-cycle pulse: hold reached LONG_MS
repeat_pulse  out  1  one-cycle pulse every REPEAT_MS after long_pulse while held
key_hold  out  1  level; 1 while the FSM considers the key pressed

Behaviour:
- Reset: sys_clk single domain; sys_rst_n asynchronous, active-low. On reset all outputs are 0, FSM is in IDLE, and the ms prescaler and ms_cnt are 0. Reset asserted mid-sequence aborts it with no pulse.
- Events: press = key_flag & !key_value; release = key_flag & key_value. key_value is ignored when key_flag is 0.
- Redundant events are ignored: press in PRESSED1, PRESSED2 or LONG_HOLD; release in IDLE or WAIT2.
- ms tick: prescaler counts 0..CLK_FREQ/1000-1 and wraps. tick is 1 in the cycle the count equals the maximum. The prescaler is free-running and never restarted.
- ms_cnt: cleared to 0 on every state entry; increments on tick; saturates at its maximum. Width is clog2(max(LONG_MS, DCLICK_MS, REPEAT_MS)) + 1.
- "Reaches N" means tick is 1 and ms_cnt == N-1. Because the prescaler is free-running, the first ms after a state entry may be short; intervals are accurate to -1 ms.
- FSM states: IDLE, PRESSED1, WAIT2, PRESSED2, LONG_HOLD.
- IDLE: press -> PRESSED1.
- PRESSED1: release -> WAIT2. Reaches LONG_MS -> pulse long_pulse, go to LONG_HOLD.
- LONG_HOLD: reaches REPEAT_MS -> pulse repeat_pulse and clear ms_cnt (periodic). release -> IDLE with no other pulse.
- WAIT2: press -> PRESSED2. Reaches DCLICK_MS -> pulse short_pulse, go to IDLE.
- PRESSED2: release -> pulse double_pulse, go to IDLE. There is no long detection in PRESSED2.
- Priority: a key event in the same cycle as a timeout wins. PRESSED1 release at the LONG_MS edge -> WAIT2, no long_pulse. WAIT2 press at the DCLICK_MS edge -> PRESSED2, no short_pulse.
- Latency: all outputs are registered. Each pulse is high exactly one cycle, in the cycle after the triggering event or tick.
- key_hold is 1 while the state is PRESSED1, PRESSED2 or LONG_HOLD. It rises the cycle after the press and falls the cycle after the release.
- At most one pulse output is high in any cycle.

Decomposition:
- Shared package key_pkg: state enum (IDLE, PRESSED1, WAIT2, PRESSED2, LONG_HOLD), KEY_PRESSED = 1'b0 constant, and a function computing cycles per ms from CLK_FREQ.
- One sub-module: ms_tick_gen (parameter CLK_FREQ; ports sys_clk, sys_rst_n, tick). It is reusable by other timing blocks.

Test Plan:
Bench uses CLK_FREQ=10_000 (10 cycles/ms), LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3.
1. Short click: press, release after 3 ms, no further events -> exactly one short_pulse about 5 ms after release; key_hold high only during the press; no other pulses.
2. Double click: press, release at 2 ms, press at 2 ms after release, release at 2 ms -> one double_pulse the cycle after the second release; no short_pulse.
3. Long with repeat: press held 20 ms, then release -> long_pulse at about 10 ms, repeat_pulse at about 13, 16 and 19 ms; no pulse at release; key_hold falls the cycle after release.
4. Simultaneous edge: release flag in the exact cycle PRESSED1 reaches LONG_MS -> no long_pulse; short_pulse follows after DCLICK_MS. Repeat with a press at the WAIT2 timeout edge -> no short_pulse, FSM in PRESSED2.
5. Redundant flags: key_flag with key_value=1 in IDLE, then key_flag with key_value=0 twice in PRESSED1 -> no state change from the redundant flags; ms_cnt is not cleared.
6. Reset mid-op: assert sys_rst_n=0 during LONG_HOLD -> all outputs 0 immediately; after release of reset no pulses until a fresh press.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the key event classifier and its ms timebase.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED1,
        WAIT2,
        PRESSED2,
        LONG_HOLD
    } key_state_e;

    localparam logic KEY_PRESSED = 1'b0;

    // Bit positions inside the registered pulse vector.
    localparam int P_SHORT  = 0;
    localparam int P_DOUBLE = 1;
    localparam int P_LONG   = 2;
    localparam int P_REPEAT = 3;
    localparam int P_NUM    = 4;

    function automatic int cycles_per_ms(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Key input (from debouncer) and event outputs (to application) of one key.
interface key_event_ctrl_if;
    logic key_flag;
    logic key_value;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic key_hold;

    modport master (
        output key_flag, key_value,
        input  short_pulse, double_pulse, long_pulse, repeat_pulse, key_hold
    );

    modport slave (
        input  key_flag, key_value,
        output short_pulse, double_pulse, long_pulse, repeat_pulse, key_hold
    );
endinterface

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms prescaler; tick is high in the last cycle of each ms.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);
    localparam int CPM = cycles_per_ms(CLK_FREQ);
    localparam int PW  = (CPM > 1) ? $clog2(CPM) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CPM - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = (presc_q == PRESC_MAX);

endmodule

// File: rtl/key_event_ctrl.sv
// Turns debounced key press/release events into short, double, long and
// auto-repeat pulses, timed in milliseconds from a free-running tick.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    key_event_ctrl_if.slave  kif
);
    localparam int CNT_W = $clog2(max3(LONG_MS, DCLICK_MS, REPEAT_MS)) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

    logic             tick;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [P_NUM-1:0] pulse_q, pulse_d;
    logic             hold_q, hold_d;
    logic             press, release_ev, restart;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    assign press      = kif.key_flag && (kif.key_value == KEY_PRESSED);
    assign release_ev = kif.key_flag && (kif.key_value != KEY_PRESSED);

    // Key events are tested before timeouts so a coincident event wins.
    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        pulse_d  = '0;
        restart  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press) state_d = PRESSED1;
            end
            PRESSED1: begin
                if (release_ev) begin
                    state_d = WAIT2;
                end else if (tick && ms_cnt_q == LONG_LAST) begin
                    pulse_d[P_LONG] = 1'b1;
                    state_d         = LONG_HOLD;
                end
            end
            LONG_HOLD: begin
                if (release_ev) begin
                    state_d = IDLE;
                end else if (tick && ms_cnt_q == REPEAT_LAST) begin
                    pulse_d[P_REPEAT] = 1'b1;
                    restart           = 1'b1;
                end
            end
            WAIT2: begin
                if (press) begin
                    state_d = PRESSED2;
                end else if (tick && ms_cnt_q == DCLICK_LAST) begin
                    pulse_d[P_SHORT] = 1'b1;
                    state_d          = IDLE;
                end
            end
            PRESSED2: begin
                if (release_ev) begin
                    pulse_d[P_DOUBLE] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (restart || (state_d != state_q)) begin
            ms_cnt_d = '0;
        end else if (tick && (ms_cnt_q != CNT_MAX)) begin
            ms_cnt_d = ms_cnt_q + 1'b1;
        end

        hold_d = (state_d == PRESSED1) || (state_d == PRESSED2) ||
                 (state_d == LONG_HOLD);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            hold_q   <= hold_d;
        end
    end

    for (genvar gi = 0; gi < P_NUM; gi++) begin : g_pulse
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                pulse_q[gi] <= 1'b0;
            end else begin
                pulse_q[gi] <= pulse_d[gi];
            end
        end
    end

    assign kif.short_pulse  = pulse_q[P_SHORT];
    assign kif.double_pulse = pulse_q[P_DOUBLE];
    assign kif.long_pulse   = pulse_q[P_LONG];
    assign kif.repeat_pulse = pulse_q[P_REPEAT];
    assign kif.key_hold     = hold_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed and randomized stimulus for key_event_ctrl against an event-level model.
module tb_key_event_ctrl;

    localparam int CLK_FREQ  = 10_000;
    localparam int CPM       = CLK_FREQ / 1000;
    localparam int LONG_MS   = 10;
    localparam int DCLICK_MS = 5;
    localparam int REPEAT_MS = 3;

    localparam int M_IDLE = 0, M_DOWN1 = 1, M_GAP = 2, M_DOWN2 = 3, M_HELD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    key_event_ctrl_if kif ();

    key_event_ctrl #(
        .CLK_FREQ  (CLK_FREQ),
        .LONG_MS   (LONG_MS),
        .DCLICK_MS (DCLICK_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .kif       (kif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: cycle position inside the ms, phase of the gesture and
    // whole milliseconds elapsed in that phase.
    int m_phase = M_IDLE;
    int m_ms    = 0;
    int m_presc = 0;
    bit e_short, e_double, e_long, e_rep, e_hold;

    int n_short, n_double, n_long, n_rep;
    int step_no;

    function automatic void model_reset();
        m_phase = M_IDLE; m_ms = 0; m_presc = 0;
        e_short = 0; e_double = 0; e_long = 0; e_rep = 0; e_hold = 0;
    endfunction

    function automatic void model_step(bit flag, bit val);
        bit ms_end = (m_presc == CPM - 1);
        bit pr     = flag && !val;
        bit rl     = flag && val;
        int nxt    = m_phase;
        bit again  = 0;
        m_presc = (m_presc + 1) % CPM;
        e_short = 0; e_double = 0; e_long = 0; e_rep = 0;
        case (m_phase)
            M_IDLE:  if (pr) nxt = M_DOWN1;
            M_DOWN1: if (rl) nxt = M_GAP;
                     else if (ms_end && m_ms + 1 == LONG_MS) begin e_long = 1; nxt = M_HELD; end
            M_HELD:  if (rl) nxt = M_IDLE;
                     else if (ms_end && m_ms + 1 == REPEAT_MS) begin e_rep = 1; again = 1; end
            M_GAP:   if (pr) nxt = M_DOWN2;
                     else if (ms_end && m_ms + 1 == DCLICK_MS) begin e_short = 1; nxt = M_IDLE; end
            M_DOWN2: if (rl) begin e_double = 1; nxt = M_IDLE; end
            default: nxt = M_IDLE;
        endcase
        if (nxt != m_phase || again) m_ms = 0;
        else if (ms_end) m_ms++;
        m_phase = nxt;
        e_hold  = (m_phase == M_DOWN1) || (m_phase == M_DOWN2) || (m_phase == M_HELD);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_short = 0; n_double = 0; n_long = 0; n_rep = 0;
    endtask

    task automatic step(input bit flag, input bit val);
        kif.key_flag  = flag;
        kif.key_value = val;
        @(posedge clk);
        model_step(flag, val);
        @(negedge clk);
        step_no++;
        n_short  += int'(kif.short_pulse);
        n_double += int'(kif.double_pulse);
        n_long   += int'(kif.long_pulse);
        n_rep    += int'(kif.repeat_pulse);
        check_bit("short_pulse",  kif.short_pulse,  e_short);
        check_bit("double_pulse", kif.double_pulse, e_double);
        check_bit("long_pulse",   kif.long_pulse,   e_long);
        check_bit("repeat_pulse", kif.repeat_pulse, e_rep);
        check_bit("key_hold",     kif.key_hold,     e_hold);
        check_bit("one_hot_pulse",
                  ($countones({kif.short_pulse, kif.double_pulse, kif.long_pulse,
                               kif.repeat_pulse}) <= 1), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        int delay;
        int gap;
        step_no = 0;
        kif.key_flag  = 1'b0;
        kif.key_value = 1'b1;
        model_reset();
        #2;
        check_bit("reset_short",  kif.short_pulse,  1'b0);
        check_bit("reset_double", kif.double_pulse, 1'b0);
        check_bit("reset_long",   kif.long_pulse,   1'b0);
        check_bit("reset_repeat", kif.repeat_pulse, 1'b0);
        check_bit("reset_hold",   kif.key_hold,     1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: short click
        clear_counts();
        idle(7);
        step(1, 0);
        check_bit("t1_hold_rise", kif.key_hold, 1'b1);
        idle(30);
        step(1, 1);
        check_bit("t1_hold_fall", kif.key_hold, 1'b0);
        idle(80);
        check_int("t1_short_cnt", n_short, 1);
        check_int("t1_other_cnt", n_double + n_long + n_rep, 0);

        // 2: double click
        clear_counts();
        step(1, 0); idle(20); step(1, 1); idle(20); step(1, 0); idle(20);
        step(1, 1);
        check_bit("t2_double_now", kif.double_pulse, 1'b1);
        idle(80);
        check_int("t2_double_cnt", n_double, 1);
        check_int("t2_short_cnt", n_short, 0);

        // 3: long press with auto-repeat
        clear_counts();
        step(1, 0);
        idle(205);
        step(1, 1);
        check_bit("t3_hold_fall", kif.key_hold, 1'b0);
        idle(80);
        check_int("t3_long_cnt", n_long, 1);
        check_int("t3_repeat_cnt", n_rep, 3);
        check_int("t3_other_cnt", n_short + n_double, 0);

        // 4a: release coincides with the long timeout
        clear_counts();
        step(1, 0);
        for (int i = 0; i < 300 && !(m_phase == M_DOWN1 && m_presc == CPM - 1
                                     && m_ms == LONG_MS - 1); i++) idle(1);
        check_int("t4_long_edge_found", m_ms, LONG_MS - 1);
        step(1, 1);
        idle(80);
        check_int("t4_long_cnt", n_long, 0);
        check_int("t4_short_cnt", n_short, 1);

        // 4b: second press coincides with the double-click timeout
        clear_counts();
        step(1, 0); idle(15); step(1, 1);
        for (int i = 0; i < 300 && !(m_phase == M_GAP && m_presc == CPM - 1
                                     && m_ms == DCLICK_MS - 1); i++) idle(1);
        check_int("t4_gap_edge_found", m_ms, DCLICK_MS - 1);
        step(1, 0);
        check_bit("t4_in_pressed2", kif.key_hold, 1'b1);
        idle(30);
        step(1, 1);
        check_bit("t4_double_now", kif.double_pulse, 1'b1);
        idle(40);
        check_int("t4_short_cnt2", n_short, 0);

        // 5: redundant flags are ignored and do not restart the timer
        clear_counts();
        step(1, 1);
        check_bit("t5_idle_release", kif.key_hold, 1'b0);
        step(1, 0);
        delay = 0;
        idle(30); step(1, 0); idle(20); step(1, 0);
        delay = 52;
        while (n_long == 0 && delay < 150) begin
            idle(1);
            delay++;
        end
        check_int("t5_long_delay_ok", int'(delay >= 90 && delay <= 101), 1);
        step(1, 1);
        idle(40);
        check_int("t5_long_cnt", n_long, 1);

        // 6: reset during LONG_HOLD
        clear_counts();
        step(1, 0);
        idle(120);
        check_bit("t6_pre_hold", kif.key_hold, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t6_rst_hold",   kif.key_hold,     1'b0);
        check_bit("t6_rst_long",   kif.long_pulse,   1'b0);
        check_bit("t6_rst_repeat", kif.repeat_pulse, 1'b0);
        check_bit("t6_rst_short",  kif.short_pulse,  1'b0);
        check_bit("t6_rst_double", kif.double_pulse, 1'b0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        for (int i = 0; i < 120; i++) step(1'b0, 1'b0);
        check_int("t6_no_pulses", n_short + n_double + n_long + n_rep, 0);

        // Randomized gestures, including ignored key_value while key_flag is low
        for (int k = 0; k < 60; k++) begin
            step(1'b1, 1'($urandom % 2));
            gap = $urandom_range(0, 140);
            for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom % 2));
        end
        idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
